vx_exec_sop_arb: RTL and testbench

Packet-aware round-robin arbiter that merges `NUM_REQS` issue-side `VX_execute_if` streams onto one functional-unit `VX_execute_if` port. A multi-beat instruction (`sop` … `eop`, successive `pid`) is never interleaved with another requester's beats: the grant is held from the `sop` beat through the `eop` beat. The block sits between the per-issue-slice dispatch outputs and a shared execute unit (ALU/LSU/SFU/vector). It also keeps a back-pressure counter and a sticky framing-error flag.

---
 rtl/vx_exec_sop_arb_pkg.sv | 20 ++
 rtl/VX_execute_if.sv | 17 +
 rtl/vx_exec_sop_arb_pipe_buffer.sv | 44 ++++
 rtl/vx_exec_sop_arb.sv | 127 ++++++++++++
 tb/tb_vx_exec_sop_arb.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_exec_sop_arb_pkg.sv
// Shared beat layout and sizing helpers for the packet-aware execute-stream arbiter.
// Each beat is a flat vector: {payload, pid, eop, sop}, with sop in bit 0.
package vx_exec_sop_arb_pkg;

    localparam int EXEC_PID_W        = 4;
    localparam int EXEC_SOP_BIT      = 0;
    localparam int EXEC_EOP_BIT      = 1;
    localparam int EXEC_PID_LSB      = 2;
    localparam int PERF_CTR_BITS_DEF = 32;

    // 32-bit PC plus one 32-bit operand per lane on top of the framing fields.
    function automatic int exec_data_width(input int lanes);
        return 2 + EXEC_PID_W + 32 + 32 * lanes;
    endfunction

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/VX_execute_if.sv
// Issue-to-execute stream: valid/ready handshake, a beat moves when both are high
// on a rising clock edge; valid must not depend on ready.
interface VX_execute_if
    import vx_exec_sop_arb_pkg::*;
#(
    parameter int NUM_LANES = 1
);
    localparam int DATA_W = exec_data_width(NUM_LANES);

    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_exec_sop_arb_pipe_buffer.sv
// Optional single-entry output stage: DEPTH=0 is a wire, DEPTH=1 a full-throughput register.
// The register reloads whenever it is empty or being drained, so it never adds a bubble.
module vx_exec_sop_arb_pipe_buffer #(
    parameter int DATAW = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [DATAW-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    input  logic             i_ready
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ reset;
            assign o_valid = i_valid;
            assign o_data  = i_data;
            assign o_ready = i_ready;
        end else begin : g_reg
            logic             r_valid;
            logic [DATAW-1:0] r_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (o_ready) begin
                    r_valid <= i_valid;
                    r_data  <= i_data;
                end
            end

            assign o_ready = !r_valid || i_ready;
            assign o_valid = r_valid;
            assign o_data  = r_data;
        end
    endgenerate

endmodule

// File: rtl/vx_exec_sop_arb.sv
// Round-robin merge of NUM_REQS execute streams that never interleaves the beats of a
// multi-beat packet; also counts output stall cycles and flags sop/eop framing errors.
module vx_exec_sop_arb
    import vx_exec_sop_arb_pkg::*;
#(
    parameter int NUM_REQS      = 4,
    parameter int NUM_LANES     = 1,
    parameter int OUT_BUF       = 1,
    parameter int PERF_CTR_BITS = PERF_CTR_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    VX_execute_if.slave                   execute_in_if [NUM_REQS],
    VX_execute_if.master                  execute_out_if,
    output logic [log2up(NUM_REQS)-1:0]   out_sel,
    output logic [PERF_CTR_BITS-1:0]      perf_stalls,
    output logic                          proto_err
);

    localparam int SEL_W  = log2up(NUM_REQS);
    localparam int DATA_W = exec_data_width(NUM_LANES);
    localparam int BUF_W  = SEL_W + DATA_W;

    logic [NUM_REQS-1:0] w_in_valid;
    logic [DATA_W-1:0]   w_in_data [NUM_REQS];

    logic                r_locked;
    logic [SEL_W-1:0]    r_lock_idx;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;
    logic                r_proto_err;

    logic                w_grant_valid;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [SEL_W-1:0]    w_scan_idx;
    logic [DATA_W-1:0]   w_grant_data;
    logic                w_arb_valid;
    logic                w_buf_ready;
    logic                w_fire;
    logic                w_sop;
    logic                w_eop;
    logic [SEL_W-1:0]    w_next_ptr;
    logic                w_out_valid;
    logic [BUF_W-1:0]    w_out_buf;

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
            assign w_in_valid[i]          = execute_in_if[i].valid;
            assign w_in_data[i]           = execute_in_if[i].data;
            assign execute_in_if[i].ready = w_fire && (w_grant_idx == SEL_W'(i));
        end
    endgenerate

    // While locked only the packet owner may move; an idle owner leaves a bubble.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        if (r_locked) begin
            w_grant_idx   = r_lock_idx;
            w_grant_valid = w_in_valid[r_lock_idx];
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                w_scan_idx = SEL_W'((int'(r_rr_ptr) + k) % NUM_REQS);
                if (!w_grant_valid && w_in_valid[w_scan_idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = w_scan_idx;
                end
            end
        end
    end

    assign w_grant_data = w_in_data[w_grant_idx];
    assign w_arb_valid  = w_grant_valid && !reset;
    assign w_fire       = w_arb_valid && w_buf_ready;
    assign w_sop        = w_grant_data[EXEC_SOP_BIT];
    assign w_eop        = w_grant_data[EXEC_EOP_BIT];
    assign w_next_ptr   = (w_grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : w_grant_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked      <= 1'b0;
            r_lock_idx    <= '0;
            r_rr_ptr      <= '0;
            r_perf_stalls <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            if (w_fire) begin
                // A packet must open with sop exactly when no packet is in flight.
                if (w_sop == r_locked) begin
                    r_proto_err <= 1'b1;
                end
                if (w_eop) begin
                    r_locked <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                end else begin
                    r_locked   <= 1'b1;
                    r_lock_idx <= w_grant_idx;
                end
            end
            if (w_out_valid && !execute_out_if.ready) begin
                r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(1);
            end
        end
    end

    vx_exec_sop_arb_pipe_buffer #(
        .DATAW (BUF_W),
        .DEPTH (OUT_BUF)
    ) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_arb_valid),
        .i_data  ({w_grant_idx, w_grant_data}),
        .o_ready (w_buf_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_buf),
        .i_ready (execute_out_if.ready)
    );

    assign execute_out_if.valid = w_out_valid;
    assign execute_out_if.data  = w_out_buf[DATA_W-1:0];
    assign out_sel              = w_out_buf[BUF_W-1 -: SEL_W];
    assign perf_stalls          = r_perf_stalls;
    assign proto_err            = r_proto_err;

endmodule

// File: tb/tb_vx_exec_sop_arb.sv
// Directed bench for vx_exec_sop_arb (4 requesters, registered output).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_vx_exec_sop_arb;
    import vx_exec_sop_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = exec_data_width(1);

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  tb_valid;
    logic [DW-1:0] tb_data [N];
    logic [N-1:0]  tb_ready;
    logic          out_ready;
    logic [1:0]    out_sel;
    logic [31:0]   perf_stalls;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    VX_execute_if #(.NUM_LANES(1)) in_if [N] ();
    VX_execute_if #(.NUM_LANES(1)) out_if ();

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign in_if[g].valid = tb_valid[g];
        assign in_if[g].data  = tb_data[g];
        assign tb_ready[g]    = in_if[g].ready;
    end
    assign out_if.ready = out_ready;

    vx_exec_sop_arb #(
        .NUM_REQS      (N),
        .NUM_LANES     (1),
        .OUT_BUF       (1),
        .PERF_CTR_BITS (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .execute_in_if  (in_if),
        .execute_out_if (out_if),
        .out_sel        (out_sel),
        .perf_stalls    (perf_stalls),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [63:0] pay, input logic [3:0] pid,
                                         input logic sop, input logic eop);
        return {pay, pid, eop, sop};
    endfunction

    function automatic logic [1:0] oh2idx(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tb_valid = 4'b0101;
        tb_data[0] = mk(64'h11, 4'd0, 1'b1, 1'b1);
        tb_data[2] = mk(64'h22, 4'd0, 1'b1, 1'b1);
        next_cycle();
        @(negedge clk);
        checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_if.valid); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", out_sel); end
        checks++; if (tb_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", tb_ready); end
        checks++; if (perf_stalls !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", perf_stalls); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto: got %0b expected 0", proto_err); end
        next_cycle();
        reset    = 1'b0;
        tb_valid = 4'b0000;
    endtask

    task automatic test_basic();
        logic [DW-1:0] d2, d3;
        d2 = mk(64'hA2, 4'd0, 1'b1, 1'b1);
        d3 = mk(64'hA3, 4'd0, 1'b1, 1'b1);
        tb_valid   = 4'b0100;
        tb_data[2] = d2;
        @(negedge clk);
        checks++; if (tb_ready !== 4'b0100) begin errors++; $display("FAIL basic_ready: got %b expected 0100", tb_ready); end
        next_cycle();
        tb_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_if.valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", out_if.valid); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL basic_sel: got %0d expected 2", out_sel); end
        checks++; if (out_if.data !== d2) begin errors++; $display("FAIL basic_data: got %0h expected %0h", out_if.data, d2); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL basic_proto: got %0b expected 0", proto_err); end
        next_cycle();
        // rr_ptr should now point at requester 3.
        tb_valid = 4'b1111;
        for (int i = 0; i < N; i++) tb_data[i] = mk(64'hB0 + 64'(i), 4'd0, 1'b1, 1'b1);
        tb_data[3] = d3;
        @(negedge clk);
        checks++; if (tb_ready !== 4'b1000) begin errors++; $display("FAIL basic_rrptr: got %b expected 1000", tb_ready); end
        next_cycle();
        tb_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_sel !== 2'd3 || out_if.data !== d3) begin errors++; $display("FAIL basic_sel3: got sel %0d data %0h expected sel 3 data %0h", out_sel, out_if.data, d3); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_idx;
        logic [1:0]    prev_idx;
        logic [DW-1:0] prev_data;
        prev_idx  = 2'd0;
        prev_data = '0;
        for (int c = 0; c < 8; c++) begin
            exp_idx  = 2'(c % 4);
            tb_valid = 4'b1111;
            for (int i = 0; i < N; i++) tb_data[i] = mk(64'h100 * 64'(c) + 64'(i), 4'd0, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if (tb_ready !== 4'(1 << exp_idx)) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, tb_ready, 4'(1 << exp_idx)); end
            if (c > 0) begin
                checks++;
                if (out_if.valid !== 1'b1 || out_sel !== prev_idx || out_if.data !== prev_data) begin
                    errors++;
                    $display("FAIL rr_out[%0d]: got v%0b sel %0d data %0h expected v1 sel %0d data %0h",
                             c, out_if.valid, out_sel, out_if.data, prev_idx, prev_data);
                end
            end
            prev_idx  = exp_idx;
            prev_data = tb_data[exp_idx];
            next_cycle();
        end
        tb_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_sel !== 2'd3 || out_if.data !== prev_data) begin errors++; $display("FAIL rr_last: got sel %0d data %0h expected sel 3 data %0h", out_sel, out_if.data, prev_data); end
        next_cycle();
    endtask

    task automatic test_packet_lock();
        logic [3:0]    vm  [9];
        logic [3:0]    rdy [9];
        logic [3:0]    r1p [9];
        logic [8:0]    r1s;
        logic [8:0]    r1e;
        logic [3:0]    prev_rdy;
        logic [DW-1:0] prev_data;
        vm  = '{4'b0001, 4'b1011, 4'b1001, 4'b1011, 4'b1011, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
        rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
        r1p = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
        r1s = 9'b000000010;
        r1e = 9'b000010000;
        prev_rdy  = 4'b0000;
        prev_data = '0;
        for (int c = 0; c < 9; c++) begin
            tb_valid   = vm[c];
            tb_data[0] = mk(64'h0A00 + 64'(c), 4'd0, 1'b1, 1'b1);
            tb_data[1] = mk(64'h1B00 + 64'(c), r1p[c], r1s[c], r1e[c]);
            tb_data[2] = '0;
            tb_data[3] = mk(64'h3D00 + 64'(c), 4'd0, 1'b1, 1'b1);
            @(negedge clk);
            checks++; if (tb_ready !== rdy[c]) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected %b", c, tb_ready, rdy[c]); end
            checks++; if (out_if.valid !== (prev_rdy != 4'b0000)) begin errors++; $display("FAIL lock_valid[%0d]: got %0b expected %0b", c, out_if.valid, prev_rdy != 4'b0000); end
            if (prev_rdy != 4'b0000) begin
                checks++;
                if (out_sel !== oh2idx(prev_rdy) || out_if.data !== prev_data) begin
                    errors++;
                    $display("FAIL lock_out[%0d]: got sel %0d data %0h expected sel %0d data %0h",
                             c, out_sel, out_if.data, oh2idx(prev_rdy), prev_data);
                end
            end
            prev_rdy  = rdy[c];
            prev_data = tb_data[oh2idx(rdy[c])];
            next_cycle();
        end
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL lock_proto: got %0b expected 0", proto_err); end
        next_cycle();
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] db, dc;
        db = mk(64'hBEEF, 4'd0, 1'b1, 1'b1);
        dc = mk(64'hCAFE, 4'd0, 1'b1, 1'b1);
        tb_valid   = 4'b0100;
        tb_data[2] = db;
        @(negedge clk);
        checks++; if (tb_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_ready: got %b expected 0100", tb_ready); end
        next_cycle();
        out_ready  = 1'b0;
        tb_valid   = 4'b0001;
        tb_data[0] = dc;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (out_if.valid !== 1'b1 || out_sel !== 2'd2 || out_if.data !== db) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v%0b sel %0d data %0h expected v1 sel 2 data %0h",
                         j, out_if.valid, out_sel, out_if.data, db);
            end
            checks++; if (tb_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", j, tb_ready); end
            checks++; if (perf_stalls !== 32'(j)) begin errors++; $display("FAIL bp_perf[%0d]: got %0d expected %0d", j, perf_stalls, j); end
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (perf_stalls !== 32'd5) begin errors++; $display("FAIL bp_perf_total: got %0d expected 5", perf_stalls); end
        checks++; if (tb_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b expected 0001", tb_ready); end
        next_cycle();
        tb_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_sel !== 2'd0 || out_if.data !== dc) begin errors++; $display("FAIL bp_next: got sel %0d data %0h expected sel 0 data %0h", out_sel, out_if.data, dc); end
        next_cycle();
    endtask

    task automatic test_framing_locked();
        logic [DW-1:0] b2;
        b2 = mk(64'hF2, 4'd2, 1'b0, 1'b1);
        tb_valid   = 4'b0010;
        tb_data[1] = mk(64'hF0, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (tb_ready !== 4'b0010) begin errors++; $display("FAIL fl_ready0: got %b expected 0010", tb_ready); end
        next_cycle();
        tb_data[1] = mk(64'hF1, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL fl_proto_before: got %0b expected 0", proto_err); end
        checks++; if (tb_ready !== 4'b0010) begin errors++; $display("FAIL fl_ready1: got %b expected 0010", tb_ready); end
        next_cycle();
        tb_data[1] = b2;
        @(negedge clk);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL fl_proto_set: got %0b expected 1", proto_err); end
        next_cycle();
        tb_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_sel !== 2'd1 || out_if.data !== b2 || proto_err !== 1'b1) begin errors++; $display("FAIL fl_out: got sel %0d data %0h perr %0b expected sel 1 data %0h perr 1", out_sel, out_if.data, proto_err, b2); end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (proto_err !== 1'b0 || out_if.valid !== 1'b0) begin errors++; $display("FAIL fl_reset: got perr %0b valid %0b expected 0 0", proto_err, out_if.valid); end
        next_cycle();
    endtask

    task automatic test_framing_unlocked();
        logic [DW-1:0] d0, dr;
        d0 = mk(64'hE0, 4'd1, 1'b0, 1'b1);
        dr = mk(64'hE2, 4'd0, 1'b1, 1'b1);
        tb_valid   = 4'b0001;
        tb_data[0] = d0;
        @(negedge clk);
        checks++; if (tb_ready !== 4'b0001 || proto_err !== 1'b0) begin errors++; $display("FAIL fu_ready0: got rdy %b perr %0b expected 0001 0", tb_ready, proto_err); end
        next_cycle();
        tb_valid   = 4'b0010;
        tb_data[1] = mk(64'hE1, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (tb_ready !== 4'b0010) begin errors++; $display("FAIL fu_ready1: got %b expected 0010", tb_ready); end
        checks++; if (out_sel !== 2'd0 || out_if.data !== d0) begin errors++; $display("FAIL fu_fwd: got sel %0d data %0h expected sel 0 data %0h", out_sel, out_if.data, d0); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL fu_proto: got %0b expected 1", proto_err); end
        next_cycle();
        reset      = 1'b1;
        tb_valid   = 4'b0100;
        tb_data[2] = dr;
        @(negedge clk);
        checks++; if (tb_ready !== 4'b0000) begin errors++; $display("FAIL fu_reset_ready: got %b expected 0000", tb_ready); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (tb_ready !== 4'b0100) begin errors++; $display("FAIL fu_unlock_ready: got %b expected 0100", tb_ready); end
        checks++; if (out_if.valid !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL fu_after_reset: got valid %0b perr %0b expected 0 0", out_if.valid, proto_err); end
        next_cycle();
        tb_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_if.valid !== 1'b1 || out_sel !== 2'd2 || out_if.data !== dr) begin errors++; $display("FAIL fu_req2_out: got v%0b sel %0d data %0h expected v1 sel 2 data %0h", out_if.valid, out_sel, out_if.data, dr); end
        next_cycle();
    endtask

    initial begin
        reset     = 1'b1;
        tb_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) tb_data[i] = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_packet_lock();
        test_back_pressure();
        test_framing_locked();
        test_framing_unlocked();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
